inv_clarke_pipe: RTL and testbench
==================================

# inv_clarke_pipe

- Pipelined inverse Clarke transform for the FOC datapath: converts a stationary-frame (alpha, beta) sample back into three-phase (a, b, c) quantities for the PWM/SVPWM stage.
- Mirror of the forward Clarke block, using the same signed fixed-point format (D_WIDTH total bits, Q_BITS fractional).
- Two-stage pipeline with valid/ready handshakes on both sides, full throughput, per-sample saturation flag.

## Interface
- D_WIDTH, 18: total signed width of all data ports.
- Q_BITS, 15: fractional bits; 1.0 = 2**Q_BITS.
- clk  in  1  clock; all state updates on rising edge.
- rstb  in  1  reset, asynchronous, active-low.
- alpha  in  D_WIDTH  signed alpha component.
- beta  in  D_WIDTH  signed beta component.
- in_valid  in  1  alpha/beta valid this cycle.
- in_ready  out  1  block accepts a sample when in_valid && in_ready.
- a, b, c  out  D_WIDTH each  signed phase outputs.
- out_valid  out  1  a/b/c/sat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- sat  out  1  b or c of the current output sample was clamped.

## Operation
- Math: a = alpha; b = -alpha/2 + K*beta; c = -alpha/2 - K*beta.
- K = round(0.8660254038 * 2**Q_BITS), a localparam; 28378 at Q_BITS=15.
- Stage 1, on accept:
  - Register a1 = alpha.
  - Register h1 = alpha >>> 1 (arithmetic, floors toward -inf).
  - Register p1 = beta * K, full signed product, D_WIDTH+Q_BITS+1 bits, no truncation.
  - Set v1.
- Stage 2, on advance:
  - t = p1 >>> Q_BITS (arithmetic, floor; no rounding).
  - bs = t - h1 and cs = -h1 - t, each computed at D_WIDTH+Q_BITS+2 bits so no intermediate overflow.
  - Saturate bs and cs to [-2**(D_WIDTH-1), 2**(D_WIDTH-1)-1].
  - a = a1, never saturated.
  - sat = 1 if either bs or cs clamped.
  - Set out_valid.
- Flow control is a standard stall pipeline:
  - adv2 = v1 && (!out_valid || out_ready).
  - adv1 = in_valid && in_ready.
  - in_ready = !v1 || adv2, combinational from registered state and out_ready.
  - v1 clears when adv2 occurs without adv1.
  - out_valid clears when out_ready && out_valid without adv2.
- No combinational path from in_valid to out_valid.
- Outputs a, b, c and sat must hold stable while out_valid && !out_ready.
- No sample is dropped or duplicated; output order equals input order.

## Timing
- Reset values: a=0, b=0, c=0, sat=0, out_valid=0, v1=0, all datapath regs 0.
- in_ready is 1 out of reset.
- Latency: sample accepted at edge N appears with out_valid=1 after edge N+1, i.e. 2 cycles, with out_ready held high.
- Throughput: 1 sample/cycle sustained when out_ready=1.
- Backpressure, out_ready=0 with both stages full:
  - in_ready=0 the same cycle.
  - The pipeline holds 2 samples.
  - in_ready returns to 1 combinationally in the first cycle out_ready=1.
- Simultaneous accept and drain in the same cycle is legal at both stages and must not lose data.
- Reset asserted mid-stream: all valids clear immediately (async); in-flight samples are discarded and outputs return to 0.
- alpha/beta are sampled only on accept; changes while in_ready=0 have no effect.

## Test plan
- alpha=16384, beta=0, out_ready=1 -> 2 cycles later a=16384, b=-8192, c=-8192, sat=0.
- alpha=0, beta=32768 -> a=0, b=28378, c=-28378, sat=0.
- alpha=-1, beta=0 -> h1=-1 (floor), so a=-1, b=1, c=1.
- alpha=-131072, beta=131071:
  - product 3719532838 gives t=113511.
  - bs=179047 clamps, so b=131071 and sat=1.
  - a=-131072, c=-47975.
- Random stream of 1000 samples with random in_valid and out_ready:
  - Outputs match the golden model in order, with no loss or duplication.
  - a/b/c stay stable during every stall.
  - in_ready=0 only when both stages are full and out_ready=0.
- Assert rstb low for 1 cycle while 2 samples are in flight:
  - out_valid=0 and a=b=c=0 immediately.
  - The next accepted sample emerges correctly 2 cycles after accept.

Source files
------------

// File: rtl/inv_clarke_if.sv
// Stream bundle for the inverse Clarke stage: alpha/beta in, a/b/c/sat out.
// Both sides use valid/ready: a beat transfers on a rising edge where valid && ready.
interface inv_clarke_if #(
    parameter int D_WIDTH = 18
) ();
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [D_WIDTH-1:0] a;
    logic signed [D_WIDTH-1:0] b;
    logic signed [D_WIDTH-1:0] c;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sat;

    modport master (
        output alpha, beta, in_valid, out_ready,
        input  in_ready, a, b, c, out_valid, sat
    );

    modport slave (
        input  alpha, beta, in_valid, out_ready,
        output in_ready, a, b, c, out_valid, sat
    );
endinterface

// File: rtl/inv_clarke_pipe.sv
// Two-stage inverse Clarke transform: (alpha, beta) -> (a, b, c) with b/c saturation.
// Stage 1 registers alpha, alpha/2 and beta*K; stage 2 combines, clamps and holds under backpressure.
module inv_clarke_pipe #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15
) (
    input  logic          clk,
    input  logic          rstb,
    inv_clarke_if.slave   bus,
    output logic          dbg_v1
);
    localparam int P_W = D_WIDTH + Q_BITS + 1;
    localparam int S_W = D_WIDTH + Q_BITS + 2;
    localparam int K   = $rtoi(0.8660254038 * (2.0 ** Q_BITS) + 0.5);
    localparam logic signed [P_W-1:0] K_P   = P_W'(K);
    localparam logic signed [S_W-1:0] S_MAX = {{(S_W-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [S_W-1:0] S_MIN = {{(S_W-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

    logic signed [D_WIDTH-1:0] a1, h1;
    logic signed [P_W-1:0]     p1;
    logic                      v1;

    logic signed [D_WIDTH-1:0] a_r, b_r, c_r;
    logic                      sat_r, out_valid_r;

    logic adv1, adv2, in_ready_c;

    logic signed [P_W-1:0]     p_next;
    logic signed [P_W-1:0]     t;
    logic signed [S_W-1:0]     bs, cs;
    logic signed [D_WIDTH-1:0] b_next, c_next;
    logic                      b_clip, c_clip;

    // in_ready depends only on registered state and out_ready, never on in_valid
    always_comb begin
        adv2       = v1 && (!out_valid_r || bus.out_ready);
        in_ready_c = !v1 || adv2;
        adv1       = bus.in_valid && in_ready_c;
    end

    always_comb begin
        p_next = P_W'(bus.beta) * K_P;
        t      = p1 >>> Q_BITS;
        bs     = S_W'(t) - S_W'(h1);
        cs     = -S_W'(h1) - S_W'(t);
        b_clip = 1'b0;
        c_clip = 1'b0;
        b_next = bs[D_WIDTH-1:0];
        c_next = cs[D_WIDTH-1:0];
        if (bs > S_MAX) begin
            b_next = S_MAX[D_WIDTH-1:0];
            b_clip = 1'b1;
        end else if (bs < S_MIN) begin
            b_next = S_MIN[D_WIDTH-1:0];
            b_clip = 1'b1;
        end
        if (cs > S_MAX) begin
            c_next = S_MAX[D_WIDTH-1:0];
            c_clip = 1'b1;
        end else if (cs < S_MIN) begin
            c_next = S_MIN[D_WIDTH-1:0];
            c_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a1 <= '0;
            h1 <= '0;
            p1 <= '0;
            v1 <= 1'b0;
        end else begin
            if (adv1) begin
                a1 <= bus.alpha;
                h1 <= bus.alpha >>> 1;
                p1 <= p_next;
            end
            if (adv1)      v1 <= 1'b1;
            else if (adv2) v1 <= 1'b0;
        end
    end

    // Output register only loads on adv2, so a/b/c/sat hold while stalled
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_r         <= '0;
            b_r         <= '0;
            c_r         <= '0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (adv2) begin
                a_r         <= a1;
                b_r         <= b_next;
                c_r         <= c_next;
                sat_r       <= b_clip || c_clip;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.a         = a_r;
    assign bus.b         = b_r;
    assign bus.c         = c_r;
    assign bus.sat       = sat_r;
    assign bus.out_valid = out_valid_r;
    assign dbg_v1        = v1;
endmodule

// File: tb/tb_inv_clarke_pipe.sv
// Bench for inv_clarke_pipe: directed vector table, backpressure and reset sequences, random stream.
module tb_inv_clarke_pipe;
  localparam int DW = 18;
  localparam int PW = 3 * DW + 1;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic dbg_v1;
  always #5 clk = ~clk;

  inv_clarke_if #(.D_WIDTH(DW)) bus ();

  inv_clarke_pipe #(.D_WIDTH(DW), .Q_BITS(15)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .bus    (bus),
    .dbg_v1 (dbg_v1)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    int alpha;
    int beta;
    int ea;
    int eb;
    int ec;
    bit esat;
  } vec_t;

  vec_t vecs[7];
  logic [PW-1:0] exp_q[$];

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input int al, input int be);
    longint p, t, h, bs, cs;
    bit s;
    p = longint'(be) * 28378;
    t = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
    h = (al >= 0) ? al / 2 : -((-al + 1) / 2);
    bs = t - h;
    cs = -h - t;
    s = 1'b0;
    if (bs > 131071) begin bs = 131071; s = 1'b1; end
    if (bs < -131072) begin bs = -131072; s = 1'b1; end
    if (cs > 131071) begin cs = 131071; s = 1'b1; end
    if (cs < -131072) begin cs = -131072; s = 1'b1; end
    return {s, DW'(cs), DW'(bs), DW'(al)};
  endfunction

  function automatic logic [PW-1:0] dut_out();
    return {bus.sat, bus.c, bus.b, bus.a};
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    bus.alpha = DW'(v.alpha);
    bus.beta = DW'(v.beta);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.alpha = DW'($urandom);
    bus.beta = DW'($urandom);
    check($sformatf("%s lat1_valid", tag), longint'(bus.out_valid), 0);
    @(negedge clk);
    check($sformatf("%s lat2_valid", tag), longint'(bus.out_valid), 1);
    check($sformatf("%s a", tag), longint'(int'(bus.a)), v.ea);
    check($sformatf("%s b", tag), longint'(int'(bus.b)), v.eb);
    check($sformatf("%s c", tag), longint'(int'(bus.c)), v.ec);
    check($sformatf("%s sat", tag), longint'(bus.sat), longint'(v.esat));
  endtask

  initial begin
    logic [PW-1:0] held, got, exp;
    bit stalled;
    int acc, cyc;

    vecs[0] = '{16384, 0, 16384, -8192, -8192, 1'b0};
    vecs[1] = '{0, 32768, 0, 28378, -28378, 1'b0};
    vecs[2] = '{-1, 0, -1, 1, 1, 1'b0};
    vecs[3] = '{-131072, 131071, -131072, 131071, -47975, 1'b1};
    vecs[4] = '{0, -1, 0, -1, 1, 1'b0};
    vecs[5] = '{131071, -131072, 131071, -131072, 47977, 1'b1};
    vecs[6] = '{131071, 0, 131071, -65535, -65535, 1'b0};

    // clock/reset
    bus.alpha = '0;
    bus.beta = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst out_valid", longint'(bus.out_valid), 0);
    check("rst a", longint'(int'(bus.a)), 0);
    check("rst b", longint'(int'(bus.b)), 0);
    check("rst c", longint'(int'(bus.c)), 0);
    check("rst sat", longint'(bus.sat), 0);
    check("rst in_ready", longint'(bus.in_ready), 1);
    rstb = 1'b1;

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // backpressure: fill both stages, stall, then release
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.alpha = DW'(vecs[0].alpha);
    bus.beta = DW'(vecs[0].beta);
    @(negedge clk);
    bus.alpha = DW'(vecs[1].alpha);
    bus.beta = DW'(vecs[1].beta);
    @(negedge clk);
    bus.alpha = DW'(vecs[3].alpha);
    bus.beta = DW'(vecs[3].beta);
    #1;
    check("bp in_ready_full", longint'(bus.in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp hold a", longint'(int'(bus.a)), vecs[0].ea);
      check("bp hold b", longint'(int'(bus.b)), vecs[0].eb);
      check("bp in_ready", longint'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp in_ready_release", longint'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp second b", longint'(int'(bus.b)), vecs[1].eb);
    check("bp second valid", longint'(bus.out_valid), 1);
    @(negedge clk);
    check("bp third b", longint'(int'(bus.b)), vecs[3].eb);
    check("bp third sat", longint'(bus.sat), 1);
    @(negedge clk);
    check("bp drained", longint'(bus.out_valid), 0);

    // reset with two samples in flight
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.alpha = DW'(vecs[3].alpha);
    bus.beta = DW'(vecs[3].beta);
    @(negedge clk);
    bus.alpha = DW'(vecs[5].alpha);
    bus.beta = DW'(vecs[5].beta);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid inflight", longint'(bus.out_valid && dbg_v1), 1);
    rstb = 1'b0;
    #1;
    check("mid out_valid", longint'(bus.out_valid), 0);
    check("mid v1", longint'(dbg_v1), 0);
    check("mid abc", longint'(bus.a != 0 || bus.b != 0 || bus.c != 0), 0);
    @(negedge clk);
    rstb = 1'b1;
    apply_vec(vecs[0], "post_rst");

    // random stream with scoreboard
    acc = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (acc < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (stalled) check("rand stall_stable", longint'(dut_out()), longint'(held));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.alpha = DW'($urandom_range(0, 262143));
      bus.beta = DW'($urandom_range(0, 262143));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rand in_ready", longint'(bus.in_ready),
            longint'(!(dbg_v1 && bus.out_valid && !bus.out_ready)));
      stalled = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          got = dut_out();
          if (exp_q.size() == 0) check("rand extra_out", 1, 0);
          else begin
            exp = exp_q.pop_front();
            check("rand out", longint'(got), longint'(exp));
          end
        end else begin
          stalled = 1'b1;
          held = dut_out();
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(int'(bus.alpha), int'(bus.beta)));
        acc++;
      end
    end
    check("rand accepted", acc, 1000);

    @(negedge clk);
    if (stalled) check("rand stall_stable", longint'(dut_out()), longint'(held));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("drain extra_out", 1, 0);
        else begin
          exp = exp_q.pop_front();
          check("drain out", longint'(dut_out()), longint'(exp));
        end
      end
      @(negedge clk);
    end
    check("drain queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
